pr_arbiter_ctrl: RTL and testbench
==================================

# pr_arbiter_ctrl

Sequential request arbiter built around the priority-encoder datapath. It samples a `wordLen`-bit request vector, registers a one-hot grant to the highest-priority requester and holds that grant until the owner releases it or a hold-timeout preempts it. It sits in front of a shared resource, such as a bus port or a functional unit, that the `pr_encoder_*` blocks would otherwise only steer combinationally.

## Interface
- `wordLen`, default 8: number of requesters. Must be ≥ 2.
- `MAX_HOLD`, default 4: maximum consecutive cycles a grant may be held.
  - 0 disables the timeout.
  - Legal range is 0..255.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: reset, **synchronous, active-high**.
- `req` input `wordLen`: request vector. Bit i high means requester i wants the resource. Bit `wordLen-1` is highest fixed priority.
- `gnt` output `wordLen`: registered one-hot grant, or all-zero.
- `gnt_valid` output 1: equals OR of `gnt`.
- `gnt_id` output `$clog2(wordLen)`: binary index of the granted bit. Holds its last value when `gnt_valid`=0.
- `preempt` output 1: one-cycle pulse on the cycle `gnt` first reads zero after a timeout revocation.

## Operation
- FSM states: IDLE, GRANT.
- **IDLE:**
  - If `req & ~mask` ≠ 0, select the winner by priority. Next edge: `gnt` is the one-hot winner, `gnt_id` is its index, state goes to GRANT, `hold_cnt` goes to 0.
  - Otherwise remain in IDLE with `gnt`=0.
- **GRANT:** let the owner be `gnt_id`. Checks are applied in this order:
  1. `req[owner]`=0: release. Next edge `gnt`=0, state IDLE, `mask` cleared, `preempt`=0.
  2. `MAX_HOLD`≠0 and `hold_cnt`==`MAX_HOLD-1`: timeout. Next edge `gnt`=0, `preempt`=1, state IDLE, `mask` = one-hot(owner).
  3. Otherwise keep `gnt`. `hold_cnt` increments, saturating at `MAX_HOLD-1`.
- `mask` applies to exactly one IDLE arbitration and is cleared on the edge leaving IDLE.
  - If only the masked requester is requesting, IDLE grants nothing that cycle. The mask then clears and the requester wins the following cycle.
- A release in the same cycle as a timeout is treated as a release: no `preempt`, no mask.
- Changes on non-owner `req` bits during GRANT are ignored. There is no mid-grant preemption by higher priority.
- `hold_cnt` width is `$clog2(MAX_HOLD+1)`, minimum 1.
- `gnt` is never multi-hot.

## Timing
- Reset values:
  - `gnt`=0, `gnt_valid`=0, `gnt_id`=0, `preempt`=0.
  - State IDLE, `hold_cnt`=0, `mask`=0.
  - RR pointer = `wordLen-1`.
- `rst` is sampled on the edge. If asserted mid-grant, `gnt` reads 0 on the following cycle and no `preempt` is generated.
- Request-to-grant latency is 1 cycle from IDLE.
- Release-to-grant-drop latency is 1 cycle, because the owner's `req` drop is sampled.
- A grant is always followed by at least one IDLE cycle with `gnt`=0. Back-to-back grants to different requesters are therefore spaced as `gnt` high…, then 0, then the new grant.
- With timeout enabled, `gnt` stays high for at most `MAX_HOLD` consecutive cycles.
- `preempt` is high for exactly 1 cycle and coincides with the first `gnt`=0 cycle.

## Configuration
- Macro `PR_ARB_RR_EN`.
- **Defined:** rotating priority.
  - A pointer `ptr` is the current highest-priority index.
  - On every grant edge to index i, `ptr` becomes (i−1) mod `wordLen`, wrapping from 0 to `wordLen-1`. The last winner becomes lowest priority.
  - The search descends from `ptr` with wrap.
  - The timeout mask still applies.
- **Undefined:** fixed priority, MSB highest. The `ptr` logic is not compiled.
- All other behaviour is identical in both builds.

## Test plan
All scenarios use `wordLen`=8 and `MAX_HOLD`=4 unless stated.
- **Basic grant and release:** reset, then `req`=8'b0010_0100.
  - Next cycle `gnt`=8'b0010_0000, `gnt_id`=5.
  - Drop `req[5]` at cycle t: `gnt`=0 at t+1, then `gnt`=8'b0000_0100 with `gnt_id`=2 at t+2.
- **Timeout:** `req`=8'b1000_1000 held.
  - `gnt`=8'b1000_0000 for exactly 4 cycles, then `gnt`=0 with `preempt`=1 for one cycle.
  - Then `gnt`=8'b0000_1000.
- **Timeout with a lone requester:** `req`=8'b0100_0000 held.
  - Pattern repeats: 4 cycles granted, 1 cycle `gnt`=0 with `preempt`, 1 masked IDLE cycle with `gnt`=0, then re-grant to bit 6.
- **Release and timeout in the same cycle:** owner drops `req` on the cycle `hold_cnt`=3.
  - `gnt`=0 next cycle, `preempt`=0, no mask.
- **Mid-grant reset:** assert `rst` during the 2nd granted cycle.
  - Next cycle all outputs are 0.
  - The subsequent grant restarts from IDLE with 1-cycle latency.
- **Rotating priority (`PR_ARB_RR_EN` defined, `MAX_HOLD`=1):** `req`=8'hFF held.
  - Grant sequence by `gnt_id` is 7, 6, 5, …, 0, 7, one grant per 2 cycles.

Source files
------------

// File: rtl/pr_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pr_arbiter_ctrl
//  Brief    : Registered one-hot request arbiter with owner hold, hold-timeout
//             preemption and one-shot requeue mask. Define PR_ARB_RR_EN for
//             rotating priority; otherwise fixed priority, MSB highest.
//  Revision : 1.0 - initial release
// ============================================================================
module pr_arbiter_ctrl #(
    parameter int wordLen  = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [wordLen-1:0]         req,
    output logic [wordLen-1:0]         gnt,
    output logic                       gnt_valid,
    output logic [$clog2(wordLen)-1:0] gnt_id,
    output logic                       preempt
);

    localparam int                c_ID_W      = $clog2(wordLen);
    localparam int                c_HC_W      = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [c_HC_W-1:0] c_HOLD_LAST = (MAX_HOLD == 0) ? '0 : c_HC_W'(MAX_HOLD - 1);
    localparam logic [0:0]        c_IDLE      = 1'b0;
    localparam logic [0:0]        c_GRANT     = 1'b1;

    logic [0:0]         r_state,    w_state_nxt;
    logic [wordLen-1:0] r_gnt,      w_gnt_nxt;
    logic [c_ID_W-1:0]  r_gnt_id,   w_gnt_id_nxt;
    logic               r_preempt,  w_preempt_nxt;
    logic [c_HC_W-1:0]  r_hold_cnt, w_hold_nxt;
    logic [wordLen-1:0] r_mask,     w_mask_nxt;
    logic [wordLen-1:0] w_cand;
    logic [c_ID_W-1:0]  w_win_id;
    logic [wordLen-1:0] w_win_oh;
`ifdef PR_ARB_RR_EN
    logic [c_ID_W-1:0]  r_ptr,      w_ptr_nxt;
`endif

    assign w_cand   = req & ~r_mask;
    assign w_win_oh = {{(wordLen-1){1'b0}}, 1'b1} << w_win_id;

    // Later loop iterations overwrite earlier hits, so the last hit is the winner.
    always_comb begin
        w_win_id = '0;
`ifdef PR_ARB_RR_EN
        for (int k = wordLen - 1; k >= 0; k--) begin
            if (w_cand[(int'(r_ptr) + wordLen - k) % wordLen]) begin
                w_win_id = c_ID_W'((int'(r_ptr) + wordLen - k) % wordLen);
            end
        end
`else
        for (int i = 0; i < wordLen; i++) begin
            if (w_cand[i]) begin
                w_win_id = c_ID_W'(i);
            end
        end
`endif
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_gnt_id_nxt  = r_gnt_id;
        w_preempt_nxt = 1'b0;
        w_hold_nxt    = r_hold_cnt;
        w_mask_nxt    = r_mask;
`ifdef PR_ARB_RR_EN
        w_ptr_nxt     = r_ptr;
`endif
        case (r_state)
            c_IDLE: begin
                // The mask only ever covers a single IDLE arbitration.
                w_mask_nxt = '0;
                w_gnt_nxt  = '0;
                if (w_cand != '0) begin
                    w_state_nxt  = c_GRANT;
                    w_gnt_nxt    = w_win_oh;
                    w_gnt_id_nxt = w_win_id;
                    w_hold_nxt   = '0;
`ifdef PR_ARB_RR_EN
                    w_ptr_nxt    = (w_win_id == '0) ? c_ID_W'(wordLen - 1) : w_win_id - 1'b1;
`endif
                end
            end
            default: begin
                if (!req[r_gnt_id]) begin
                    w_state_nxt = c_IDLE;
                    w_gnt_nxt   = '0;
                    w_mask_nxt  = '0;
                end else if (MAX_HOLD != 0 && r_hold_cnt == c_HOLD_LAST) begin
                    w_state_nxt   = c_IDLE;
                    w_gnt_nxt     = '0;
                    w_preempt_nxt = 1'b1;
                    w_mask_nxt    = r_gnt;
                end else if (MAX_HOLD != 0) begin
                    w_hold_nxt = r_hold_cnt + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_gnt      <= '0;
            r_gnt_id   <= '0;
            r_preempt  <= 1'b0;
            r_hold_cnt <= '0;
            r_mask     <= '0;
`ifdef PR_ARB_RR_EN
            r_ptr      <= c_ID_W'(wordLen - 1);
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_gnt_id   <= w_gnt_id_nxt;
            r_preempt  <= w_preempt_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_mask     <= w_mask_nxt;
`ifdef PR_ARB_RR_EN
            r_ptr      <= w_ptr_nxt;
`endif
        end
    end

    assign gnt       = r_gnt;
    assign gnt_valid = |r_gnt;
    assign gnt_id    = r_gnt_id;
    assign preempt   = r_preempt;

endmodule
`default_nettype wire

// File: tb/tb_pr_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pr_arbiter_ctrl
//  Brief    : Directed and randomized bench for pr_arbiter_ctrl against a
//             cycle-level behavioural model (PR_ARB_RR_EN aware).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pr_arbiter_ctrl;

    localparam int WL = 8;
    localparam int MH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [WL-1:0] req = '0;
    logic [WL-1:0] gnt;
    logic          gnt_valid;
    logic [2:0]    gnt_id;
    logic          preempt;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model: owner index, granted-cycle count, pending mask index.
    int m_owner   = -1;
    int m_last_id = 0;
    int m_held    = 0;
    int m_masked  = -1;
    int m_pre     = 0;
    int m_ptr     = WL - 1;

    always #5 clk = ~clk;

    pr_arbiter_ctrl #(.wordLen(WL), .MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .preempt   (preempt)
    );

    function automatic int pick(input logic [WL-1:0] c);
`ifdef PR_ARB_RR_EN
        for (int k = 0; k < WL; k++) begin
            if (c[(m_ptr - k + WL) % WL]) return (m_ptr - k + WL) % WL;
        end
`else
        for (int j = WL - 1; j >= 0; j--) begin
            if (c[j]) return j;
        end
`endif
        return -1;
    endfunction

    function automatic logic [WL-1:0] exp_gnt();
        logic [WL-1:0] one;
        one = 1;
        return (m_owner < 0) ? '0 : (one << m_owner);
    endfunction

    task automatic model_update(input logic [WL-1:0] r, input logic rs);
        logic [WL-1:0] cand;
        int w;
        if (rs) begin
            m_owner = -1; m_last_id = 0; m_held = 0; m_masked = -1; m_pre = 0; m_ptr = WL - 1;
        end else if (m_owner < 0) begin
            cand = r;
            if (m_masked >= 0) cand[m_masked] = 1'b0;
            m_masked = -1;
            m_pre    = 0;
            if (cand != '0) begin
                w = pick(cand);
                m_owner = w; m_last_id = w; m_held = 1; m_ptr = (w + WL - 1) % WL;
            end
        end else begin
            m_pre = 0;
            if (!r[m_owner]) begin
                m_owner = -1;
            end else if (MH != 0 && m_held == MH) begin
                m_masked = m_owner; m_owner = -1; m_pre = 1;
            end else begin
                m_held++;
            end
        end
    endtask

    // Apply inputs for one cycle; outputs are sampled 1 ns after the edge.
    task automatic tick(input logic [WL-1:0] r, input logic rs);
        req = r;
        rst = rs;
        @(posedge clk);
        model_update(r, rs);
        #1;
    endtask

    task automatic test_reset();
        tick(8'hFF, 1'b1);
        tick(8'hFF, 1'b1);
        n_total++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_id !== 3'd0 || preempt !== 1'b0) begin
            $display("FAIL reset: gnt=%b valid=%b id=%0d pre=%b, expected all zero", gnt, gnt_valid, gnt_id, preempt);
        end else n_pass++;
    endtask

    task automatic test_basic();
        tick(8'h00, 1'b1);
        tick(8'b0010_0100, 1'b0);
        n_total++;
        if (gnt !== 8'b0010_0000 || gnt_id !== 3'd5 || gnt_valid !== 1'b1) begin
            $display("FAIL basic_grant: gnt=%b id=%0d, expected 00100000 id 5", gnt, gnt_id);
        end else n_pass++;
        tick(8'b0010_0100, 1'b0);
        n_total++;
        if (gnt !== 8'b0010_0000) $display("FAIL basic_hold: gnt=%b, expected 00100000", gnt);
        else n_pass++;
        tick(8'b0000_0100, 1'b0);
        n_total++;
        if (gnt !== 8'h00 || preempt !== 1'b0) $display("FAIL basic_release: gnt=%b pre=%b, expected 0/0", gnt, preempt);
        else n_pass++;
        tick(8'b0000_0100, 1'b0);
        n_total++;
        if (gnt !== 8'b0000_0100 || gnt_id !== 3'd2) $display("FAIL basic_next: gnt=%b id=%0d, expected 00000100 id 2", gnt, gnt_id);
        else n_pass++;
        tick(8'h00, 1'b0);
        n_total++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_id !== 3'd2) begin
            $display("FAIL basic_id_hold: gnt=%b valid=%b id=%0d, expected 0/0/2", gnt, gnt_valid, gnt_id);
        end else n_pass++;
    endtask

    task automatic test_timeout();
        logic [WL-1:0] eg [0:5];
        logic          ep [0:5];
        eg = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h08};
        ep = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tick(8'h00, 1'b1);
        for (int k = 0; k < 6; k++) begin
            tick(8'b1000_1000, 1'b0);
            n_total++;
            if (gnt !== eg[k] || preempt !== ep[k]) begin
                $display("FAIL timeout cyc %0d: gnt=%b pre=%b, expected gnt=%b pre=%b", k, gnt, preempt, eg[k], ep[k]);
            end else n_pass++;
        end
    endtask

    task automatic test_lone();
        logic [WL-1:0] eg;
        logic          ep;
        tick(8'h00, 1'b1);
        for (int k = 0; k < 13; k++) begin
            tick(8'b0100_0000, 1'b0);
            eg = ((k % 6) < 4) ? 8'h40 : 8'h00;
            ep = ((k % 6) == 4);
            n_total++;
            if (gnt !== eg || preempt !== ep) begin
                $display("FAIL lone cyc %0d: gnt=%b pre=%b, expected gnt=%b pre=%b", k, gnt, preempt, eg, ep);
            end else n_pass++;
        end
    endtask

    task automatic test_release_timeout();
        tick(8'h00, 1'b1);
        for (int k = 0; k < 4; k++) tick(8'b0001_0000, 1'b0);
        n_total++;
        if (gnt !== 8'b0001_0000) $display("FAIL reltmo_hold: gnt=%b, expected 00010000", gnt);
        else n_pass++;
        tick(8'h00, 1'b0);
        n_total++;
        if (gnt !== 8'h00 || preempt !== 1'b0) $display("FAIL reltmo_drop: gnt=%b pre=%b, expected 0/0", gnt, preempt);
        else n_pass++;
        tick(8'b0001_0000, 1'b0);
        n_total++;
        if (gnt !== 8'b0001_0000) $display("FAIL reltmo_nomask: gnt=%b, expected 00010000", gnt);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        tick(8'h00, 1'b1);
        tick(8'b0000_0010, 1'b0);
        tick(8'b0000_0010, 1'b0);
        n_total++;
        if (gnt !== 8'b0000_0010) $display("FAIL midrst_grant: gnt=%b, expected 00000010", gnt);
        else n_pass++;
        tick(8'b0000_0010, 1'b1);
        n_total++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_id !== 3'd0 || preempt !== 1'b0) begin
            $display("FAIL midrst_clear: gnt=%b valid=%b id=%0d pre=%b, expected all zero", gnt, gnt_valid, gnt_id, preempt);
        end else n_pass++;
        tick(8'b0000_0010, 1'b0);
        n_total++;
        if (gnt !== 8'b0000_0010 || gnt_id !== 3'd1) $display("FAIL midrst_regrant: gnt=%b id=%0d, expected 00000010 id 1", gnt, gnt_id);
        else n_pass++;
    endtask

`ifdef PR_ARB_RR_EN
    task automatic test_rotate();
        int   n_gr = 0;
        logic prev = 1'b0;
        tick(8'h00, 1'b1);
        for (int c = 0; c < 120 && n_gr < 9; c++) begin
            tick(8'hFF, 1'b0);
            if (gnt_valid && !prev) begin
                n_total++;
                if (int'(gnt_id) !== (WL - 1 - n_gr + WL) % WL) begin
                    $display("FAIL rotate grant %0d: id=%0d, expected %0d", n_gr, gnt_id, (WL - 1 - n_gr + WL) % WL);
                end else n_pass++;
                n_gr++;
            end
            prev = gnt_valid;
        end
        n_total++;
        if (n_gr < 9) $display("FAIL rotate_bound: grants=%0d, expected 9", n_gr);
        else n_pass++;
    endtask
`endif

    task automatic test_random();
        logic [WL-1:0] r;
        logic          rs;
        tick(8'h00, 1'b1);
        for (int c = 0; c < 600; c++) begin
            r  = WL'($urandom & $urandom);
            rs = ($urandom_range(0, 63) == 0);
            tick(r, rs);
            n_total++;
            if (gnt !== exp_gnt() || gnt_valid !== (m_owner >= 0) || int'(gnt_id) !== m_last_id
                || preempt !== m_pre[0] || !$onehot0(gnt)) begin
                $display("FAIL random cyc %0d: gnt=%b id=%0d pre=%b, expected gnt=%b id=%0d pre=%0d",
                         c, gnt, gnt_id, preempt, exp_gnt(), m_last_id, m_pre);
            end else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_lone();
        test_release_timeout();
        test_mid_reset();
`ifdef PR_ARB_RR_EN
        test_rotate();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
